msk_aes_shiftrows_buffer: RTL and testbench
===========================================

MSK_AES_SHIFTROWS_BUFFER -- requirements
Module: msk_aes_shiftrows_buffer

Interface
REQ-001 SHALL have parameter d, default 2: number of shares per masked bit.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port inverse, input, 1 bit: 0 = forward ShiftRows, 1 = inverse ShiftRows; sampled on the first accepted input column of a block.
REQ-005 SHALL have port in_valid, input, 1 bit: input column valid.
REQ-006 SHALL have port in_ready, output, 1 bit: buffer can accept a column.
REQ-007 SHALL have port in_col, input, 32*d bits: masked column; row r byte shares at [8*d*r +: 8*d].
REQ-008 SHALL have port out_valid, output, 1 bit: output column valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream MixColumns stage accepts a column.
REQ-010 SHALL have port out_col, output, 32*d bits: shifted masked column, same packing as in_col.
REQ-011 SHALL have port out_inverse, output, 1 bit: latched direction of the block being drained.
REQ-012 SHALL have port out_last, output, 1 bit: high with the fourth output column of a block.

Function
REQ-013 SHALL hold a 16-byte masked state S[r][c], each byte 8*d bits, registered only.
REQ-014 SHALL implement FSM states FILL and DRAIN with a 2-bit column counter cnt.
REQ-015 In FILL, in_ready SHALL be 1 and out_valid 0; on in_valid&in_ready, S[r][cnt] <= in_col row r and cnt increments.
REQ-016 On the first accepted column (cnt=0), inverse SHALL be latched into out_inverse; later changes of inverse within the block SHALL be ignored.
REQ-017 When the column with cnt=3 is accepted, FSM SHALL go to DRAIN with cnt=0 on the next cycle.
REQ-018 In DRAIN, in_ready SHALL be 0, out_valid 1, out_col row r = S[r][(cnt+r) mod 4] (forward) or S[r][(cnt-r) mod 4] (inverse).
REQ-019 On out_valid&out_ready, cnt SHALL increment; out_last = 1 when cnt=3; acceptance at cnt=3 returns FSM to FILL with cnt=0.
REQ-020 With out_ready=0, out_col, out_last and cnt SHALL hold stable; no timeout.
REQ-021 First output column SHALL appear the cycle after the fourth input column is accepted (latency 1 cycle); no fill/drain overlap, throughput 4 columns per 8 cycles at best.
REQ-022 Datapath SHALL only permute whole bytes share-by-share: no share of one byte SHALL be combined by logic with any share of another byte, and shares of the same byte SHALL never be combined.
REQ-023 Output mux SHALL select from registered state only; out_col SHALL have no combinational path from in_col.
REQ-024 in_valid while in DRAIN SHALL be ignored (in_ready=0); out_ready in FILL SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL immediately force FSM=FILL, cnt=0, out_valid=0, out_last=0, out_inverse=0, in_ready=1 after release.
REQ-026 State bytes S SHALL be cleared to zero on reset to avoid leaking stale shares.
REQ-027 Reset mid-fill or mid-drain SHALL discard the partial block; the next accepted column is column 0.

Verification (d=2; input byte 4*c+r: share0 = 4*c+r, share1 = 0)
REQ-028 Forward: load 4 columns inverse=0, out_ready=1 -> out columns share0 rows {00,05,0A,0F},{04,09,0E,03},{08,0D,02,07},{0C,01,06,0B}, out_last on 4th, share1 all 0.
REQ-029 Inverse: same load inverse=1 -> first out column {00,0D,0A,07}; toggle inverse after column 0 -> output unchanged, out_inverse=1.
REQ-030 Backpressure: out_ready=0 for 5 cycles in DRAIN cnt=1 -> out_col constant {04,09,0E,03}, in_ready=0, then resume completes block correctly.
REQ-031 Share independence: share1 random R, share0 = data^R -> per-share outputs follow the same permutation; XOR of shares equals unmasked ShiftRows.
REQ-032 Reset mid-drain at cnt=2 -> out_valid=0 immediately; new block loaded after reset outputs only new data.
REQ-033 Back-to-back blocks with in_valid held high -> in_ready drops exactly 4 cycles of drain, no column lost or duplicated.

Source files
------------

// File: rtl/msk_aes_shiftrows_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : msk_aes_shiftrows_buffer
//  Description : Column-serial masked AES ShiftRows. Four columns are
//                collected into a registered 4x4 byte state, then drained
//                as four row-rotated columns. Bytes move share-by-share and
//                are never combined with other bytes or with their own shares.
//  Revision    : 1.0 - initial release
// ============================================================================
module msk_aes_shiftrows_buffer #(
   parameter int d = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inverse,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [32*d-1:0] in_col,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [32*d-1:0] out_col,
   output logic            out_inverse,
   output logic            out_last
);

   // One masked byte: d shares of 8 bits each.
   localparam int BW = 8 * d;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] cnt;
   logic [1:0] cnt_nxt;
   logic       in_fire;

   assign in_fire = in_valid & in_ready;

   // FSM state and column counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, counter advance and handshake outputs
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (cnt == 2'd3);
            if (out_ready) begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state_nxt = FILL;
               end
            end
         end
         default: begin
            state_nxt = FILL;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // Direction is captured with column 0 and held for the whole block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_inverse <= 1'b0;
      end else if (in_fire && (cnt == 2'd0)) begin
         out_inverse <= inverse;
      end
   end

   // Each state row lives in its own register bank; the output byte for that
   // row is a pure mux over the registered bank, rotated by the row index.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam logic [1:0] ROW = 2'(r);

      logic [BW-1:0] row_q [4];
      logic [1:0]    sel;

      // Capture row r of each accepted column; cleared on reset so no stale
      // shares remain visible
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
               row_q[c] <= '0;
            end
         end else if (in_fire) begin
            row_q[cnt] <= in_col[BW*r +: BW];
         end
      end

      // Modulo-4 wrap comes for free from the 2-bit arithmetic
      assign sel = out_inverse ? (cnt - ROW) : (cnt + ROW);
      assign out_col[BW*r +: BW] = row_q[sel];
   end

endmodule
`default_nettype wire

// File: tb/tb_msk_aes_shiftrows_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msk_aes_shiftrows_buffer
//  Description : Self-checking bench for msk_aes_shiftrows_buffer (d=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msk_aes_shiftrows_buffer;

   localparam int D = 2;
   localparam int W = 32 * D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         inverse;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_col;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_col;
   logic         out_inverse;
   logic         out_last;

   int errors = 0;
   int checks = 0;

   // Reference blocks: blks[block][row][col] = {share1, share0}
   logic [15:0] blks  [2][4][4];
   // Unmasked data behind blks[0] for the share-independence scenario
   logic [7:0]  plain [4][4];

   always #5 clk = ~clk;

   msk_aes_shiftrows_buffer #(.d(D)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inverse     (inverse),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_col      (in_col),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_col     (out_col),
      .out_inverse (out_inverse),
      .out_last    (out_last)
   );

   // Pack input column c of block b
   function automatic logic [W-1:0] col_of(input int b, input int c);
      logic [W-1:0] v;
      for (int r = 0; r < 4; r++) v[16*r +: 16] = blks[b][r][c];
      return v;
   endfunction

   // ShiftRows reference: row r is rotated left by r (forward) or right by r
   function automatic logic [W-1:0] exp_col(input int b, input int c, input bit inv);
      logic [W-1:0] v;
      int src;
      for (int r = 0; r < 4; r++) begin
         src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
         v[16*r +: 16] = blks[b][r][src];
      end
      return v;
   endfunction

   function automatic void fill_index(input int b);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            blks[b][r][c] = {8'h00, 8'(4*c + r)};
   endfunction

   function automatic void fill_masked();
      logic [7:0] m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            plain[r][c]    = 8'($urandom);
            m              = 8'($urandom);
            blks[0][r][c]  = {m, plain[r][c] ^ m};
         end
   endfunction

   function automatic void fill_random(input int b);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            blks[b][r][c] = 16'($urandom);
   endfunction

   // Present four columns on consecutive cycles; returns at the negedge
   // where the first drained column should be visible
   task automatic load_block(input int b, input bit inv, input bit toggle);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_col   = col_of(b, c);
         inverse  = (toggle && c > 0) ? ~inv : inv;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_col   = '0;
      inverse  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_inverse !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b l=%b i=%b exp 0 0 0", out_valid, out_last, out_inverse);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_forward();
      logic [31:0]  tab [4];
      logic [W-1:0] tv;
      tab[0] = 32'h0F0A0500;
      tab[1] = 32'h030E0904;
      tab[2] = 32'h07020D08;
      tab[3] = 32'h0B06010C;
      out_ready = 1'b1;
      fill_index(0);
      load_block(0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) tv[16*r +: 16] = {8'h00, tab[c][8*r +: 8]};
         checks++;
         if (out_valid !== 1'b1 || out_col !== tv) begin
            errors++;
            $display("FAIL fwd_table c=%0d got v=%b col=%h exp v=1 col=%h", c, out_valid, out_col, tv);
         end
         checks++;
         if (out_col !== exp_col(0, c, 1'b0) || out_last !== 1'(c == 3) || out_inverse !== 1'b0) begin
            errors++;
            $display("FAIL fwd_model c=%0d got col=%h last=%b inv=%b exp col=%h last=%b inv=0",
                     c, out_col, out_last, out_inverse, exp_col(0, c, 1'b0), 1'(c == 3));
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL fwd_back_to_fill got v=%b rdy=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_inverse();
      out_ready = 1'b1;
      fill_index(0);
      load_block(0, 1'b1, 1'b1);
      checks++;
      if (out_col !== {16'h0007, 16'h000A, 16'h000D, 16'h0000}) begin
         errors++;
         $display("FAIL inv_first_col got %h exp %h", out_col, {16'h0007, 16'h000A, 16'h000D, 16'h0000});
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_col !== exp_col(0, c, 1'b1) ||
             out_last !== 1'(c == 3) || out_inverse !== 1'b1) begin
            errors++;
            $display("FAIL inv_col c=%0d got v=%b col=%h last=%b inv=%b exp v=1 col=%h last=%b inv=1",
                     c, out_valid, out_col, out_last, out_inverse, exp_col(0, c, 1'b1), 1'(c == 3));
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      fill_index(0);
      load_block(0, 1'b0, 1'b0);
      // column 0 accepted at once
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_col !== {16'h0003, 16'h000E, 16'h0009, 16'h0004} || in_ready !== 1'b0 ||
             out_valid !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold k=%0d got col=%h rdy=%b v=%b last=%b exp col=%h rdy=0 v=1 last=0",
                     k, out_col, in_ready, out_valid, out_last, {16'h0003, 16'h000E, 16'h0009, 16'h0004});
         end
      end
      out_ready = 1'b1;
      for (int c = 1; c < 4; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_col !== exp_col(0, c, 1'b0) || out_last !== 1'(c == 3)) begin
            errors++;
            $display("FAIL bp_resume c=%0d got v=%b col=%h last=%b exp v=1 col=%h last=%b",
                     c, out_valid, out_col, out_last, exp_col(0, c, 1'b0), 1'(c == 3));
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_end got v=%b rdy=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_share_independence();
      logic [31:0] got_x;
      logic [31:0] exp_x;
      out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         fill_masked();
         load_block(0, 1'b0, 1'b0);
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               got_x[8*r +: 8] = out_col[16*r +: 8] ^ out_col[16*r+8 +: 8];
               exp_x[8*r +: 8] = plain[r][(c + r) % 4];
            end
            checks++;
            if (out_col !== exp_col(0, c, 1'b0)) begin
               errors++;
               $display("FAIL share_col t=%0d c=%0d got %h exp %h", t, c, out_col, exp_col(0, c, 1'b0));
            end
            checks++;
            if (got_x !== exp_x) begin
               errors++;
               $display("FAIL share_unmasked t=%0d c=%0d got %h exp %h", t, c, got_x, exp_x);
            end
            @(posedge clk);
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      bit inv;
      out_ready = 1'b1;
      fill_random(0);
      inv = 1'($urandom);
      load_block(0, inv, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (out_col !== exp_col(0, 2, inv)) begin
         errors++;
         $display("FAIL rst_pre_col got %h exp %h", out_col, exp_col(0, 2, inv));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_inverse !== 1'b0 || out_col !== '0) begin
         errors++;
         $display("FAIL rst_mid_drain got v=%b l=%b i=%b col=%h exp 0 0 0 0",
                  out_valid, out_last, out_inverse, out_col);
      end
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready got %b exp 1", in_ready);
      end
      fill_random(0);
      inv = 1'($urandom);
      load_block(0, inv, 1'b0);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_col !== exp_col(0, c, inv) ||
             out_last !== 1'(c == 3) || out_inverse !== inv) begin
            errors++;
            $display("FAIL rst_new_block c=%0d got v=%b col=%h last=%b inv=%b exp v=1 col=%h last=%b inv=%b",
                     c, out_valid, out_col, out_last, out_inverse, exp_col(0, c, inv), 1'(c == 3), inv);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int sent;
      int recv;
      int cyc;
      bit exp_rdy;
      fill_random(0);
      fill_random(1);
      out_ready = 1'b1;
      inverse   = 1'b0;
      sent = 0;
      recv = 0;
      cyc  = 0;
      // Fill phase: fewer than four columns held since the last drain;
      // drain phase: a full block is held and not yet fully sent out.
      while (recv < 8 && cyc < 40) begin
         @(negedge clk);
         exp_rdy = !(sent > recv && (sent % 4) == 0);
         checks++;
         if (in_ready !== exp_rdy || out_valid !== !exp_rdy) begin
            errors++;
            $display("FAIL b2b_hs cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b",
                     cyc, in_ready, out_valid, exp_rdy, !exp_rdy);
         end
         if (!exp_rdy) begin
            checks++;
            if (out_col !== exp_col(recv / 4, recv % 4, 1'b0) || out_last !== 1'((recv % 4) == 3)) begin
               errors++;
               $display("FAIL b2b_col n=%0d got col=%h last=%b exp col=%h last=%b",
                        recv, out_col, out_last, exp_col(recv / 4, recv % 4, 1'b0), 1'((recv % 4) == 3));
            end
         end
         if (sent < 8) begin
            in_valid = 1'b1;
            in_col   = col_of(sent / 4, sent % 4);
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         if (exp_rdy && in_valid) sent++;
         else if (!exp_rdy) recv++;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (recv !== 8 || cyc !== 16) begin
         errors++;
         $display("FAIL b2b_total got recv=%0d cycles=%0d exp recv=8 cycles=16", recv, cyc);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      inverse   = 1'b0;
      in_valid  = 1'b0;
      in_col    = '0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_forward();
      test_inverse();
      test_backpressure();
      test_share_independence();
      test_reset_mid_drain();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
